// File: rtl/pipeline_pkg.sv
// Shared pipeline types: controller states, register/NOP constants and the
// packed set of pipeline-register controls driven by the hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HC_INIT     = 2'd0,
    HC_RUN      = 2'd1,
    HC_MEM_WAIT = 2'd2,
    HC_DRAIN    = 2'd3
  } hc_state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
  localparam ctrl_t CTRL_PASS   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: ID/EX/MEM hazard sources in, pipeline register
// controls, state and performance counters out.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic [4:0]       rd_EX;
  logic             mem_read_EX;
  logic             branch_taken_EX;
  logic             dmem_req_MEM;
  logic             dmem_ready;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_write;
  logic             MEM_WB_write;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             mem_timeout;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_read_EX,
           branch_taken_EX, dmem_req_MEM, dmem_ready,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write,
           MEM_WB_write, state_o, stall_cycles, flush_events, mem_timeout
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, mem_read_EX,
           branch_taken_EX, dmem_req_MEM, dmem_ready,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write,
           MEM_WB_write, state_o, stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: combinational advance/hold/flush decode from the current
// state and hazard inputs; state, wait counter, perf counters and timeout flag registered.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst_n,
  hazard_controller_if.slave hif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hc_state_t   state;
  hc_state_t   state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic        timeout_q;
  ctrl_t       ctrl;
  logic        mem_stall;
  logic        load_use;
  logic        flush_evt;
  logic        timeout_hit;
  logic        stall_inc;

  assign mem_stall = hif.dmem_req_MEM && !hif.dmem_ready;
  assign load_use  = hif.mem_read_EX && (hif.rd_EX != REG_ZERO) &&
                     ((hif.rs1_used_ID && (hif.rs1_ID == hif.rd_EX)) ||
                      (hif.rs2_used_ID && (hif.rs2_ID == hif.rd_EX)));

  always_comb begin
    ctrl        = CTRL_INIT;
    state_nxt   = state;
    flush_evt   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      HC_INIT: begin
        ctrl      = CTRL_INIT;
        state_nxt = HC_RUN;
      end
      HC_RUN, HC_DRAIN: begin
        // A held MEM access masks branch/load-use; EX is frozen so they resurface later.
        if (mem_stall) begin
          ctrl = CTRL_FREEZE;
        end else if (hif.branch_taken_EX) begin
          ctrl      = CTRL_BRANCH;
          flush_evt = 1'b1;
        end else if (load_use) begin
          ctrl = CTRL_BUBBLE;
        end else begin
          ctrl = CTRL_PASS;
        end
        state_nxt = (state == HC_RUN && mem_stall) ? HC_MEM_WAIT : HC_RUN;
      end
      HC_MEM_WAIT: begin
        if (hif.dmem_ready) begin
          ctrl      = CTRL_PASS;
          state_nxt = HC_DRAIN;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            state_nxt   = HC_DRAIN;
          end
        end
      end
      default: begin
        ctrl      = CTRL_INIT;
        state_nxt = HC_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HC_INIT;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == HC_DRAIN) begin
        wait_cnt <= '0;
      end else if (state == HC_MEM_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_inc = !ctrl.pc_write && (state != HC_INIT);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (hif.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_evt),
    .count (hif.flush_events)
  );

  assign hif.pc_write     = ctrl.pc_write;
  assign hif.IF_ID_write  = ctrl.if_id_write;
  assign hif.IF_ID_flush  = ctrl.if_id_flush;
  assign hif.ID_EX_flush  = ctrl.id_ex_flush;
  assign hif.EX_MEM_write = ctrl.ex_mem_write;
  assign hif.MEM_WB_write = ctrl.mem_wb_write;
  assign hif.state_o      = state;
  assign hif.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and random checks of hazard_controller against a cycle-level behavioural model.
module tb_hazard_controller;

  localparam int CNT_W   = 4;
  localparam int TO      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CNT_W)) hif ();

  hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  int errors = 0;
  int checks = 0;

  // Model: pipeline phase flags plus counters, advanced once per clock.
  bit m_init, m_wait, m_drain, m_to;
  int m_wcnt, m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    checks++;
    assert (obs === req_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req_v);
    end
  endtask

  function automatic logic [5:0] obs_ctrl();
    return {hif.pc_write, hif.IF_ID_write, hif.IF_ID_flush,
            hif.ID_EX_flush, hif.EX_MEM_write, hif.MEM_WB_write};
  endfunction

  function automatic bit hazard_now();
    return hif.mem_read_EX && (hif.rd_EX != 5'd0) &&
           ((hif.rs1_used_ID && hif.rs1_ID == hif.rd_EX) ||
            (hif.rs2_used_ID && hif.rs2_ID == hif.rd_EX));
  endfunction

  // {pc, if_id_wr, if_id_flush, id_ex_flush, ex_mem_wr, mem_wb_wr}
  function automatic logic [5:0] exp_ctrl();
    bit mstall;
    mstall = hif.dmem_req_MEM && !hif.dmem_ready;
    if (m_init) return 6'b001111;
    if (m_wait) return hif.dmem_ready ? 6'b110011 : 6'b000000;
    if (mstall) return 6'b000000;
    if (hif.branch_taken_EX) return 6'b111111;
    if (hazard_now()) return 6'b000111;
    return 6'b110011;
  endfunction

  function automatic int exp_state();
    if (m_init)  return 0;
    if (m_wait)  return 2;
    if (m_drain) return 3;
    return 1;
  endfunction

  task automatic set_in(input int r1, input int r2, input bit u1, input bit u2, input int rd,
                        input bit mr, input bit br, input bit req, input bit rdy);
    hif.rs1_ID          = 5'(r1);
    hif.rs2_ID          = 5'(r2);
    hif.rs1_used_ID     = u1;
    hif.rs2_used_ID     = u2;
    hif.rd_EX           = 5'(rd);
    hif.mem_read_EX     = mr;
    hif.branch_taken_EX = br;
    hif.dmem_req_MEM    = req;
    hif.dmem_ready      = rdy;
  endtask

  task automatic idle();
    set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called just after a rising edge: check at the falling edge, then advance the model.
  task automatic step();
    logic [5:0] e;
    bit mstall, br_taken;
    @(negedge clk);
    e = exp_ctrl();
    chk("ctrl",    32'(obs_ctrl()),        32'(e));
    chk("state",   32'(hif.state_o),       32'(exp_state()));
    chk("stalls",  32'(hif.stall_cycles),  32'(m_stall));
    chk("flushes", 32'(hif.flush_events),  32'(m_flush));
    chk("timeout", 32'(hif.mem_timeout),   32'(m_to));
    mstall   = hif.dmem_req_MEM && !hif.dmem_ready;
    br_taken = !m_init && !m_wait && !mstall && hif.branch_taken_EX;
    if (!m_init && !e[5] && m_stall < CNT_MAX) m_stall++;
    if (br_taken && m_flush < CNT_MAX) m_flush++;
    if (m_init) begin
      m_init = 1'b0;
    end else if (m_wait) begin
      m_wcnt++;
      if (hif.dmem_ready) begin
        m_wait = 1'b0; m_drain = 1'b1;
      end else if (m_wcnt == TO) begin
        m_to = 1'b1; m_wait = 1'b0; m_drain = 1'b1;
      end
    end else if (m_drain) begin
      m_drain = 1'b0;
    end else if (mstall) begin
      m_wait = 1'b1; m_wcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; release before the next negedge so one INIT cycle follows.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl",    32'(obs_ctrl()),       32'h0f);
    chk("rst_state",   32'(hif.state_o),      32'd0);
    chk("rst_stalls",  32'(hif.stall_cycles), 32'd0);
    chk("rst_flushes", 32'(hif.flush_events), 32'd0);
    chk("rst_timeout", 32'(hif.mem_timeout),  32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_init  = 1'b1; m_wait = 1'b0; m_drain = 1'b0; m_to = 1'b0;
    m_wcnt  = 0;    m_stall = 0;   m_flush = 0;
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Reset release: INIT cycle then normal flow.
    step();
    step();

    // lw x5 in EX, add x6,x5,x7 in ID: one bubble, then the load has moved on.
    set_in(5, 7, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_in(5, 7, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("lu_stall_once", 32'(hif.stall_cycles), 32'd1);

    // Load into x0 never stalls.
    set_in(0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Taken branch coinciding with a load-use match: flush wins.
    set_in(5, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("br_flush_cnt", 32'(hif.flush_events), 32'd1);
    chk("br_no_stall",  32'(hif.stall_cycles), 32'd1);

    // Three not-ready cycles, ready cycle, DRAIN, RUN.
    do_reset();
    step();
    set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    hif.dmem_ready = 1'b1;
    step();
    idle();
    step();
    step();
    chk("memwait_stalls", 32'(hif.stall_cycles), 32'd3);
    chk("memwait_state",  32'(hif.state_o),      32'd1);

    // Zero-wait access in RUN.
    set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("zero_wait_state", 32'(hif.state_o), 32'd1);

    // Timeout: ready never comes.
    set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (1 + TO) step();
    chk("timeout_set",   32'(hif.mem_timeout), 32'd1);
    chk("timeout_drain", 32'(hif.state_o),     32'd3);
    idle();
    repeat (3) step();
    chk("timeout_sticky", 32'(hif.mem_timeout), 32'd1);

    // Reset mid-MEM_WAIT.
    set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    do_reset();
    idle();
    step();

    // Saturating stall counter.
    set_in(3, 0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    chk("stall_sat", 32'(hif.stall_cycles), 32'(CNT_MAX));

    // Randomized traffic with small register numbers to provoke matches.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 4) == 0),
             1'($urandom), ($urandom_range(0, 2) == 0));
      step();
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
